// File: rtl/qoa_spi_pkg.sv
// rtl/qoa_spi_pkg.sv - shared constants and state type for the QOA SPI command controller
package qoa_spi_pkg;

    localparam logic [1:0] OP_READ_REG  = 2'b00;
    localparam logic [1:0] OP_WRITE_REG = 2'b01;
    localparam logic [1:0] OP_PUSH      = 2'b10;
    localparam logic [1:0] OP_POP       = 2'b11;

    localparam logic [5:0] ADDR_CTRL    = 6'd0;
    localparam logic [5:0] ADDR_STATUS  = 6'd1;
    localparam logic [5:0] ADDR_ID      = 6'd2;
    localparam logic [5:0] ADDR_SCRATCH = 6'd3;

    localparam int STAT_IN_READY  = 0;
    localparam int STAT_OUT_VALID = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_UNDERRUN  = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_DATA   = 3'd1,
        ST_PUSH_LEN  = 3'd2,
        ST_PUSH_DATA = 3'd3,
        ST_POP       = 3'd4
    } state_e;

endpackage

// File: rtl/qoa_spi_cmd_ctrl_if.sv
// rtl/qoa_spi_cmd_ctrl_if.sv - SPI byte, decoder stream and control signals of the command controller
interface qoa_spi_cmd_ctrl_if;
    logic        cs_active;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        tx_load;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        dec_enable;
    logic        dec_flush;

    // master: the command controller itself
    modport master (
        input  cs_active, rx_valid, rx_byte, in_ready, out_sample, out_valid,
        output tx_byte, tx_load, in_data, in_valid, out_ready, dec_enable, dec_flush
    );

    modport slave (
        output cs_active, rx_valid, rx_byte, in_ready, out_sample, out_valid,
        input  tx_byte, tx_load, in_data, in_valid, out_ready, dec_enable, dec_flush
    );
endinterface

// File: rtl/qoa_spi_regfile.sv
// rtl/qoa_spi_regfile.sv - CTRL/SCRATCH storage, sticky STATUS bits and register read mux
module qoa_spi_regfile
    import qoa_spi_pkg::*;
#(
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter int         NREGS    = 4
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       i_wr_en,
    input  logic [5:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [5:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    input  logic       i_in_ready,
    input  logic       i_out_valid,
    input  logic       i_set_overrun,
    input  logic       i_set_underrun,
    output logic [7:0] o_status,
    output logic       o_dec_enable,
    output logic       o_dec_flush
);

    logic       r_enable;
    logic       r_flush;
    logic [7:0] r_scratch;
    logic       r_overrun;
    logic       r_underrun;

    logic w_wr_mapped;
    logic w_wr_ctrl;
    logic w_wr_status;
    logic w_wr_scratch;

    assign w_wr_mapped  = i_wr_en && (int'(i_wr_addr) < NREGS);
    assign w_wr_ctrl    = w_wr_mapped && (i_wr_addr == ADDR_CTRL);
    assign w_wr_status  = w_wr_mapped && (i_wr_addr == ADDR_STATUS);
    assign w_wr_scratch = w_wr_mapped && (i_wr_addr == ADDR_SCRATCH);

    // a new sticky event outranks a simultaneous write-1-to-clear
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_enable   <= 1'b0;
            r_flush    <= 1'b0;
            r_scratch  <= 8'h00;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_flush    <= w_wr_ctrl && i_wr_data[1];
            if (w_wr_ctrl)
                r_enable <= i_wr_data[0];
            if (w_wr_scratch)
                r_scratch <= i_wr_data;
            r_overrun  <= i_set_overrun ||
                          (r_overrun && !(w_wr_status && i_wr_data[STAT_OVERRUN]));
            r_underrun <= i_set_underrun ||
                          (r_underrun && !(w_wr_status && i_wr_data[STAT_UNDERRUN]));
        end
    end

    always_comb begin
        o_status                 = 8'h00;
        o_status[STAT_IN_READY]  = i_in_ready;
        o_status[STAT_OUT_VALID] = i_out_valid;
        o_status[STAT_OVERRUN]   = r_overrun;
        o_status[STAT_UNDERRUN]  = r_underrun;
    end

    always_comb begin
        o_rd_data = 8'h00;
        if (int'(i_rd_addr) < NREGS) begin
            case (i_rd_addr)
                ADDR_CTRL:    o_rd_data = {7'b0, r_enable};
                ADDR_STATUS:  o_rd_data = o_status;
                ADDR_ID:      o_rd_data = ID_VALUE;
                ADDR_SCRATCH: o_rd_data = r_scratch;
                default:      o_rd_data = 8'h00;
            endcase
        end
    end

    assign o_dec_enable = r_enable;
    assign o_dec_flush  = r_flush;

endmodule

// File: rtl/qoa_spi_cmd_ctrl.sv
// rtl/qoa_spi_cmd_ctrl.sv - decodes SPI command bytes into register, push and pop operations
module qoa_spi_cmd_ctrl
    import qoa_spi_pkg::*;
#(
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter int         NREGS    = 4
) (
    input  logic               sclk,
    input  logic               rst_n,
    qoa_spi_cmd_ctrl_if.master bus
);

    state_e     r_state;
    logic       r_armed;
    logic [5:0] r_wr_addr;
    logic [7:0] r_count;
    logic       r_phase;
    logic [7:0] r_sample_lo;
    logic [7:0] r_tx_byte;
    logic       r_tx_load;
    logic [7:0] r_in_data;
    logic       r_in_valid;
    logic       r_out_ready;

    logic       w_acc;
    logic [1:0] w_op;
    logic [5:0] w_arg;
    logic       w_wr_en;
    logic       w_pop;
    logic       w_set_overrun;
    logic       w_set_underrun;
    logic [7:0] w_rd_data;
    logic [7:0] w_status;

    // r_armed blocks parsing after reset until chip select has been seen low
    assign w_acc = bus.rx_valid && bus.cs_active && r_armed;
    assign w_op  = bus.rx_byte[7:6];
    assign w_arg = bus.rx_byte[5:0];

    always_comb begin
        w_wr_en       = 1'b0;
        w_pop         = 1'b0;
        w_set_overrun = 1'b0;
        if (w_acc) begin
            case (r_state)
                ST_IDLE:      w_pop = (w_op == OP_POP);
                ST_WR_DATA:   w_wr_en = 1'b1;
                ST_PUSH_DATA: w_set_overrun = !bus.in_ready;
                ST_POP:       w_pop = !r_phase;
                default:      ;
            endcase
        end
        w_set_underrun = w_pop && !bus.out_valid;
    end

    qoa_spi_regfile #(
        .ID_VALUE (ID_VALUE),
        .NREGS    (NREGS)
    ) u_regfile (
        .sclk           (sclk),
        .rst_n          (rst_n),
        .i_wr_en        (w_wr_en),
        .i_wr_addr      (r_wr_addr),
        .i_wr_data      (bus.rx_byte),
        .i_rd_addr      (w_arg),
        .o_rd_data      (w_rd_data),
        .i_in_ready     (bus.in_ready),
        .i_out_valid    (bus.out_valid),
        .i_set_overrun  (w_set_overrun),
        .i_set_underrun (w_set_underrun),
        .o_status       (w_status),
        .o_dec_enable   (bus.dec_enable),
        .o_dec_flush    (bus.dec_flush)
    );

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_wr_addr   <= 6'd0;
            r_count     <= 8'd0;
            r_phase     <= 1'b0;
            r_sample_lo <= 8'h00;
            r_tx_byte   <= 8'h00;
            r_tx_load   <= 1'b0;
            r_in_data   <= 8'h00;
            r_in_valid  <= 1'b0;
            r_out_ready <= 1'b0;
        end else begin
            r_tx_load   <= w_acc;
            r_in_valid  <= 1'b0;
            r_out_ready <= 1'b0;
            if (!bus.cs_active) begin
                r_armed <= 1'b1;
                r_state <= ST_IDLE;
                r_count <= 8'd0;
                r_phase <= 1'b0;
            end else if (w_acc) begin
                r_tx_byte <= w_status;
                case (r_state)
                    ST_IDLE: begin
                        case (w_op)
                            OP_READ_REG:  r_tx_byte <= w_rd_data;
                            OP_WRITE_REG: begin
                                r_wr_addr <= w_arg;
                                r_state   <= ST_WR_DATA;
                            end
                            OP_PUSH:      r_state <= ST_PUSH_LEN;
                            default:      r_state <= ST_POP;
                        endcase
                    end
                    ST_WR_DATA: r_state <= ST_IDLE;
                    ST_PUSH_LEN: begin
                        if (bus.rx_byte == 8'h00) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_count <= bus.rx_byte;
                            r_state <= ST_PUSH_DATA;
                        end
                    end
                    ST_PUSH_DATA: begin
                        if (bus.in_ready) begin
                            r_in_data  <= bus.rx_byte;
                            r_in_valid <= 1'b1;
                        end
                        r_count <= r_count - 8'd1;
                        if (r_count == 8'd1)
                            r_state <= ST_IDLE;
                    end
                    ST_POP: begin
                        if (r_phase) begin
                            r_tx_byte <= r_sample_lo;
                            r_phase   <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
                // an empty decoder output is reported as a zero sample
                if (w_pop) begin
                    r_phase     <= 1'b1;
                    r_out_ready <= bus.out_valid;
                    r_tx_byte   <= bus.out_valid ? bus.out_sample[15:8] : 8'h00;
                    r_sample_lo <= bus.out_valid ? bus.out_sample[7:0]  : 8'h00;
                end
            end
        end
    end

    assign bus.tx_byte   = r_tx_byte;
    assign bus.tx_load   = r_tx_load;
    assign bus.in_data   = r_in_data;
    assign bus.in_valid  = r_in_valid;
    assign bus.out_ready = r_out_ready;

endmodule

// File: tb/tb_qoa_spi_cmd_ctrl.sv
// tb/tb_qoa_spi_cmd_ctrl.sv - directed self-checking bench for qoa_spi_cmd_ctrl
module tb_qoa_spi_cmd_ctrl;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 sclk = ~sclk;

    qoa_spi_cmd_ctrl_if bus();

    qoa_spi_cmd_ctrl #(.ID_VALUE(8'hA5), .NREGS(4)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] c_tx, c_ind;
    logic       c_load, c_inv, c_ordy, c_flush;
    logic       n_load, n_inv, n_ordy, n_flush;

    task automatic send_byte(input logic [7:0] b);
        @(negedge sclk);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge sclk);
        bus.rx_valid = 1'b0;
        c_load = bus.tx_load;  c_tx  = bus.tx_byte;
        c_inv  = bus.in_valid; c_ind = bus.in_data;
        c_ordy = bus.out_ready; c_flush = bus.dec_flush;
        @(negedge sclk);
        n_load = bus.tx_load; n_inv = bus.in_valid;
        n_ordy = bus.out_ready; n_flush = bus.dec_flush;
        @(negedge sclk);
    endtask

    task automatic cs_on();
        @(negedge sclk);
        bus.cs_active = 1'b1;
    endtask

    task automatic cs_off();
        @(negedge sclk);
        bus.cs_active = 1'b0;
        @(negedge sclk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        n_vec++;
        if ({bus.tx_byte, bus.tx_load, bus.in_valid, bus.in_data, bus.out_ready} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_outputs tx_byte=%h tx_load=%b in_valid=%b in_data=%h out_ready=%b, want all 0",
                     bus.tx_byte, bus.tx_load, bus.in_valid, bus.in_data, bus.out_ready);
        end
        n_vec++;
        if ({bus.dec_enable, bus.dec_flush} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ctrl dec_enable=%b dec_flush=%b, want 0 0", bus.dec_enable, bus.dec_flush);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);
    endtask

    task automatic test_read_id();
        cs_on();
        send_byte(8'h02);
        n_vec++;
        if (c_load !== 1'b1 || c_tx !== 8'hA5) begin
            n_bad++;
            $display("FAIL read_id tx_load=%b tx_byte=%h, want 1 a5", c_load, c_tx);
        end
        n_vec++;
        if (n_load !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_load_width second cycle tx_load=%b, want 0", n_load);
        end
        cs_off();
    endtask

    task automatic test_write_scratch();
        cs_on();
        send_byte(8'h43);
        n_vec++;
        if (c_load !== 1'b1 || c_tx !== 8'h00) begin
            n_bad++;
            $display("FAIL wr_cmd_status tx_load=%b tx_byte=%h, want 1 00", c_load, c_tx);
        end
        send_byte(8'h5C);
        n_vec++;
        if (c_load !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_data_load tx_load=%b, want 1", c_load);
        end
        send_byte(8'h03);
        n_vec++;
        if (c_tx !== 8'h5C) begin
            n_bad++;
            $display("FAIL scratch_read tx_byte=%h, want 5c", c_tx);
        end
        cs_off();
    endtask

    task automatic test_ctrl();
        cs_on();
        send_byte(8'h40);
        send_byte(8'h03);
        n_vec++;
        if (c_flush !== 1'b1 || n_flush !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_pulse cycle1=%b cycle2=%b, want 1 0", c_flush, n_flush);
        end
        n_vec++;
        if (bus.dec_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL dec_enable got %b, want 1", bus.dec_enable);
        end
        send_byte(8'h00);
        n_vec++;
        if (c_tx !== 8'h01) begin
            n_bad++;
            $display("FAIL ctrl_read tx_byte=%h, want 01", c_tx);
        end
        cs_off();
    endtask

    task automatic test_push();
        logic [7:0] data [3];
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
        bus.in_ready = 1'b1;
        cs_on();
        send_byte(8'h80);
        send_byte(8'h03);
        n_vec++;
        if (c_inv !== 1'b0) begin
            n_bad++;
            $display("FAIL push_len_no_valid in_valid=%b, want 0", c_inv);
        end
        for (int i = 0; i < 3; i++) begin
            send_byte(data[i]);
            n_vec++;
            if (c_inv !== 1'b1 || c_ind !== data[i] || n_inv !== 1'b0) begin
                n_bad++;
                $display("FAIL push_byte%0d in_valid=%b in_data=%h next_valid=%b, want 1 %h 0",
                         i, c_inv, c_ind, n_inv, data[i]);
            end
        end
        send_byte(8'h02);
        n_vec++;
        if (c_tx !== 8'hA5 || c_inv !== 1'b0) begin
            n_bad++;
            $display("FAIL push_back_idle tx_byte=%h in_valid=%b, want a5 0", c_tx, c_inv);
        end
        cs_off();

        cs_on();
        send_byte(8'h80);
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            bus.in_ready = (i != 1);
            send_byte(data[i]);
            n_vec++;
            if (c_inv !== (i != 1)) begin
                n_bad++;
                $display("FAIL push_ovr_byte%0d in_valid=%b, want %b", i, c_inv, (i != 1));
            end
        end
        bus.in_ready = 1'b1;
        send_byte(8'h01);
        n_vec++;
        if (c_tx !== 8'h05) begin
            n_bad++;
            $display("FAIL overrun_status tx_byte=%h, want 05", c_tx);
        end
        send_byte(8'h41);
        send_byte(8'h04);
        send_byte(8'h01);
        n_vec++;
        if (c_tx !== 8'h01) begin
            n_bad++;
            $display("FAIL overrun_w1c tx_byte=%h, want 01", c_tx);
        end
        cs_off();
        bus.in_ready = 1'b0;
    endtask

    task automatic test_pop();
        logic [7:0] exp_tx [6];
        logic       exp_rdy [6];
        exp_tx  = '{8'h12, 8'h34, 8'hFE, 8'hDC, 8'h00, 8'h00};
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.out_valid  = 1'b1;
        bus.out_sample = 16'h1234;
        cs_on();
        for (int i = 0; i < 6; i++) begin
            send_byte(i == 0 ? 8'hC0 : 8'h00);
            if (c_ordy) bus.out_sample = 16'hFEDC;
            if (i == 2) bus.out_valid = 1'b0;
            n_vec++;
            if (c_tx !== exp_tx[i] || c_ordy !== exp_rdy[i] || n_ordy !== 1'b0) begin
                n_bad++;
                $display("FAIL pop_byte%0d tx_byte=%h out_ready=%b next_ready=%b, want %h %b 0",
                         i, c_tx, c_ordy, n_ordy, exp_tx[i], exp_rdy[i]);
            end
        end
        cs_off();
        cs_on();
        send_byte(8'h01);
        n_vec++;
        if (c_tx !== 8'h08) begin
            n_bad++;
            $display("FAIL underrun_status tx_byte=%h, want 08", c_tx);
        end
        send_byte(8'h41);
        send_byte(8'h08);
        cs_off();
    endtask

    task automatic test_cs_drop();
        bus.in_ready = 1'b1;
        cs_on();
        send_byte(8'h80);
        send_byte(8'h05);
        cs_off();
        cs_on();
        send_byte(8'h02);
        n_vec++;
        if (c_tx !== 8'hA5 || c_inv !== 1'b0) begin
            n_bad++;
            $display("FAIL cs_drop_fresh tx_byte=%h in_valid=%b, want a5 0", c_tx, c_inv);
        end
        @(negedge sclk);
        bus.cs_active = 1'b0;
        bus.rx_byte   = 8'h80;
        bus.rx_valid  = 1'b1;
        @(negedge sclk);
        bus.rx_valid = 1'b0;
        n_vec++;
        if (bus.tx_load !== 1'b0) begin
            n_bad++;
            $display("FAIL cs_fall_discard tx_load=%b, want 0", bus.tx_load);
        end
        cs_on();
        send_byte(8'h02);
        n_vec++;
        if (c_tx !== 8'hA5 || c_inv !== 1'b0) begin
            n_bad++;
            $display("FAIL cs_fall_fresh tx_byte=%h in_valid=%b, want a5 0", c_tx, c_inv);
        end
        cs_off();
        bus.in_ready = 1'b0;
    endtask

    task automatic test_reset_mid_pop();
        cs_on();
        send_byte(8'h40); send_byte(8'h01);
        send_byte(8'h43); send_byte(8'h77);
        cs_off();
        bus.out_valid = 1'b0;
        cs_on();
        send_byte(8'hC0);
        cs_off();
        bus.out_valid  = 1'b1;
        bus.out_sample = 16'h5555;
        cs_on();
        send_byte(8'hC0);
        n_vec++;
        if (c_ordy !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_pop out_ready=%b, want 1", c_ordy);
        end
        @(negedge sclk);
        rst_n = 1'b0;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        n_vec++;
        if (bus.dec_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dec_enable got %b, want 0", bus.dec_enable);
        end
        send_byte(8'hC0);
        n_vec++;
        if (c_load !== 1'b0 || c_ordy !== 1'b0 || n_ordy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_parse tx_load=%b out_ready=%b/%b, want 0 0/0", c_load, c_ordy, n_ordy);
        end
        cs_off();
        cs_on();
        send_byte(8'h00);
        n_vec++;
        if (c_tx !== 8'h00 || c_ordy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl_read tx_byte=%h out_ready=%b, want 00 0", c_tx, c_ordy);
        end
        send_byte(8'h03);
        n_vec++;
        if (c_tx !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_scratch_read tx_byte=%h, want 00", c_tx);
        end
        send_byte(8'h01);
        n_vec++;
        if (c_tx !== 8'h02) begin
            n_bad++;
            $display("FAIL reset_status_read tx_byte=%h, want 02", c_tx);
        end
        cs_off();
    endtask

    initial begin
        bus.cs_active  = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_byte    = 8'h00;
        bus.in_ready   = 1'b0;
        bus.out_sample = 16'h0000;
        bus.out_valid  = 1'b0;
        test_reset();
        test_read_id();
        test_write_scratch();
        test_ctrl();
        test_push();
        test_pop();
        test_cs_drop();
        test_reset_mid_pop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
